// File: rtl/async_fifo_pkg.sv
// Shared types and sizing helpers for the async FIFO write-side arbiter.
package async_fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Width of a counter that must hold values 0..max_burst.
  function automatic int unsigned beat_cnt_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/async_fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_vld
);

  // Scan NUM_REQ candidates starting at rr_ptr; the first hit wins.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_vld && req[IDX_W'(cand)]) begin
        pick_vld              = 1'b1;
        pick_idx              = IDX_W'(cand);
        pick_oh[IDX_W'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Round-robin arbiter sharing the FIFO write port; grants are held for a whole packet.
module async_fifo_wr_arb
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          W_FULL,
  output logic                          W_INC_EN,
  output logic [DATA_WIDTH-1:0]         W_DATA,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic                          BUSY
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = beat_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_REQ - 1);

  arb_state_t          state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    owner;
  logic [CNT_W-1:0]    beat_cnt;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_vld;
  logic                fire;
  logic                last_beat;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req      (REQ_VALID),
    .rr_ptr   (rr_ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // A beat moves when the owner is valid and the FIFO has room; reset suppresses the write.
  assign fire      = (state == XFER) && !RST && REQ_VALID[owner] && !W_FULL;
  assign last_beat = fire && (REQ_LAST[owner] || (beat_cnt == CNT_LAST));
  assign W_INC_EN  = fire;

  // Ready only towards the owner, and data muxed from the owner while transferring.
  always_comb begin
    REQ_READY        = '0;
    REQ_READY[owner] = fire;
    W_DATA           = '0;
    if (state == XFER) W_DATA = REQ_DATA[32'(owner)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Arbitration FSM with registered grant, owner, pointer and beat counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      GRANT    <= '0;
      BUSY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner    <= pick_idx;
            GRANT    <= pick_oh;
            BUSY     <= 1'b1;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (last_beat) begin
            state    <= IDLE;
            GRANT    <= '0;
            BUSY     <= 1'b0;
            beat_cnt <= '0;
            rr_ptr   <= (owner == IDX_TOP) ? '0 : owner + IDX_W'(1);
          end else if (fire) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Directed bench for async_fifo_wr_arb (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_async_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        w_full;
  logic        w_inc_en;
  logic [7:0]  w_data;
  logic [3:0]  grant;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // Writes seen by the FIFO: {grant, data}
  logic [11:0] wlog[$];

  async_fifo_wr_arb #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .MAX_BURST  (4)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ_VALID (req_valid),
    .REQ_DATA  (req_data),
    .REQ_LAST  (req_last),
    .REQ_READY (req_ready),
    .W_FULL    (w_full),
    .W_INC_EN  (w_inc_en),
    .W_DATA    (w_data),
    .GRANT     (grant),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (w_inc_en) wlog.push_back({grant, w_data});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_last = 4'hF; w_full = 1'b0; req_data = 32'h11223344;
    cyc(); cyc(); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_vec++; if (w_inc_en !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b expected 0", w_inc_en); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_vec++; if (w_data !== 8'h00) begin n_err++; $display("FAIL reset_wdata: got %h expected 00", w_data); end
    n_vec++; if (dut.rr_ptr !== 2'd0) begin n_err++; $display("FAIL reset_rrptr: got %0d expected 0", dut.rr_ptr); end
    rst = 1'b0; req_valid = 4'h0; req_last = 4'h0; req_data = '0;
    cyc();
  endtask

  task automatic test_single();
    logic [11:0] exp[$];
    wlog.delete();
    req_data[23:16] = 8'hA1; req_valid = 4'b0100; #1;
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL single_nogrant_yet: got %b expected 0000", grant); end
    cyc(); #1;
    n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b expected 0100", grant); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", busy); end
    n_vec++; if (w_inc_en !== 1'b1) begin n_err++; $display("FAIL single_wen: got %b expected 1", w_inc_en); end
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    n_vec++; if (w_data !== 8'hA1) begin n_err++; $display("FAIL single_wdata: got %h expected a1", w_data); end
    cyc(); req_data[23:16] = 8'hA2; #1;
    n_vec++; if (dut.beat_cnt !== 3'd1) begin n_err++; $display("FAIL single_cnt: got %0d expected 1", dut.beat_cnt); end
    cyc(); req_data[23:16] = 8'hA3; req_last = 4'b0100;
    cyc(); req_valid = 4'b0000; req_last = 4'b0000; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b expected 0", busy); end
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL single_grant_off: got %b expected 0000", grant); end
    n_vec++; if (dut.rr_ptr !== 2'd3) begin n_err++; $display("FAIL single_rrptr: got %0d expected 3", dut.rr_ptr); end
    exp = '{12'h4A1, 12'h4A2, 12'h4A3};
    n_vec++; if (wlog.size() != exp.size()) begin n_err++; $display("FAIL single_nwrites: got %0d expected %0d", wlog.size(), exp.size()); end
    else foreach (exp[i]) begin
      n_vec++; if (wlog[i] !== exp[i]) begin n_err++; $display("FAIL single_write%0d: got %h expected %h", i, wlog[i], exp[i]); end
    end
  endtask

  task automatic test_fairness();
    logic [11:0] exp[$];
    logic        exp_we;
    rst = 1'b1; cyc(); rst = 1'b0;
    wlog.delete();
    req_data = 32'h13121110; req_last = 4'hF; req_valid = 4'hF;
    for (int k = 0; k < 16; k++) begin
      cyc(); #1;
      exp_we = (k % 2 == 0);
      n_vec++; if (w_inc_en !== exp_we) begin n_err++; $display("FAIL fair_wen_c%0d: got %b expected %b", k + 1, w_inc_en, exp_we); end
    end
    req_valid = 4'h0; req_last = 4'h0;
    exp = '{12'h110, 12'h211, 12'h412, 12'h813, 12'h110, 12'h211, 12'h412, 12'h813};
    n_vec++; if (wlog.size() != exp.size()) begin n_err++; $display("FAIL fair_nwrites: got %0d expected %0d", wlog.size(), exp.size()); end
    else foreach (exp[i]) begin
      n_vec++; if (wlog[i] !== exp[i]) begin n_err++; $display("FAIL fair_write%0d: got %h expected %h", i, wlog[i], exp[i]); end
    end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [11:0] exp[$];
    wlog.delete();
    req_data[15:8] = 8'hB1; req_valid = 4'b0010;
    cyc(); cyc();
    req_data[15:8] = 8'hB2; w_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++; if (w_inc_en !== 1'b0) begin n_err++; $display("FAIL bp_wen_%0d: got %b expected 0", k, w_inc_en); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready_%0d: got %b expected 0000", k, req_ready); end
      n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL bp_grant_%0d: got %b expected 0010", k, grant); end
      n_vec++; if (dut.beat_cnt !== 3'd1) begin n_err++; $display("FAIL bp_cnt_%0d: got %0d expected 1", k, dut.beat_cnt); end
      cyc();
    end
    w_full = 1'b0; #1;
    n_vec++; if (w_inc_en !== 1'b1) begin n_err++; $display("FAIL bp_resume_wen: got %b expected 1", w_inc_en); end
    n_vec++; if (w_data !== 8'hB2) begin n_err++; $display("FAIL bp_resume_data: got %h expected b2", w_data); end
    cyc(); req_data[15:8] = 8'hB3;
    cyc(); req_data[15:8] = 8'hB4; req_last = 4'b0010;
    cyc(); req_valid = 4'b0000; req_last = 4'b0000; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b expected 0", busy); end
    exp = '{12'h2B1, 12'h2B2, 12'h2B3, 12'h2B4};
    n_vec++; if (wlog.size() != exp.size()) begin n_err++; $display("FAIL bp_nwrites: got %0d expected %0d", wlog.size(), exp.size()); end
    else foreach (exp[i]) begin
      n_vec++; if (wlog[i] !== exp[i]) begin n_err++; $display("FAIL bp_write%0d: got %h expected %h", i, wlog[i], exp[i]); end
    end
  endtask

  task automatic test_burst_cap();
    logic [11:0] exp[$];
    rst = 1'b1; cyc(); rst = 1'b0;
    wlog.delete();
    req_data[7:0] = 8'hC1; req_data[31:24] = 8'hD0; req_last = 4'b1000; req_valid = 4'b1001;
    cyc(); #1;
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL burst_grant0: got %b expected 0001", grant); end
    cyc(); req_data[7:0] = 8'hC2;
    cyc(); req_data[7:0] = 8'hC3;
    cyc(); req_data[7:0] = 8'hC4; #1;
    n_vec++; if (dut.beat_cnt !== 3'd3) begin n_err++; $display("FAIL burst_cnt: got %0d expected 3", dut.beat_cnt); end
    cyc(); req_data[7:0] = 8'hC5; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_release: got %b expected 0", busy); end
    n_vec++; if (dut.rr_ptr !== 2'd1) begin n_err++; $display("FAIL burst_rrptr1: got %0d expected 1", dut.rr_ptr); end
    cyc(); #1;
    n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL burst_grant3: got %b expected 1000", grant); end
    cyc(); req_valid = 4'b0001; req_last = 4'b0000; #1;
    n_vec++; if (dut.rr_ptr !== 2'd0) begin n_err++; $display("FAIL burst_rrptr0: got %0d expected 0", dut.rr_ptr); end
    cyc(); #1;
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL burst_regrant: got %b expected 0001", grant); end
    n_vec++; if (w_data !== 8'hC5) begin n_err++; $display("FAIL burst_c5: got %h expected c5", w_data); end
    cyc(); req_data[7:0] = 8'hC6; req_last = 4'b0001;
    cyc(); req_valid = 4'b0000; req_last = 4'b0000; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_idle: got %b expected 0", busy); end
    exp = '{12'h1C1, 12'h1C2, 12'h1C3, 12'h1C4, 12'h8D0, 12'h1C5, 12'h1C6};
    n_vec++; if (wlog.size() != exp.size()) begin n_err++; $display("FAIL burst_nwrites: got %0d expected %0d", wlog.size(), exp.size()); end
    else foreach (exp[i]) begin
      n_vec++; if (wlog[i] !== exp[i]) begin n_err++; $display("FAIL burst_write%0d: got %h expected %h", i, wlog[i], exp[i]); end
    end
  endtask

  task automatic test_valid_gap();
    logic [11:0] exp[$];
    wlog.delete();
    req_data[23:16] = 8'hE1; req_valid = 4'b0100;
    cyc(); req_data[15:8] = 8'hF1; req_last = 4'b0010; req_valid = 4'b0110;
    cyc(); req_data[23:16] = 8'hE2; req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (w_inc_en !== 1'b0) begin n_err++; $display("FAIL gap_wen_%0d: got %b expected 0", k, w_inc_en); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL gap_ready_%0d: got %b expected 0000", k, req_ready); end
      n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL gap_grant_%0d: got %b expected 0100", k, grant); end
      cyc();
    end
    req_valid = 4'b0110; #1;
    n_vec++; if (w_data !== 8'hE2) begin n_err++; $display("FAIL gap_resume: got %h expected e2", w_data); end
    cyc(); req_data[23:16] = 8'hE3; req_last = 4'b0110;
    cyc(); req_valid = 4'b0010; req_last = 4'b0010; #1;
    n_vec++; if (dut.rr_ptr !== 2'd3) begin n_err++; $display("FAIL gap_rrptr: got %0d expected 3", dut.rr_ptr); end
    cyc(); #1;
    n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL gap_next_grant: got %b expected 0010", grant); end
    cyc(); req_valid = 4'b0000; req_last = 4'b0000;
    exp = '{12'h4E1, 12'h4E2, 12'h4E3, 12'h2F1};
    n_vec++; if (wlog.size() != exp.size()) begin n_err++; $display("FAIL gap_nwrites: got %0d expected %0d", wlog.size(), exp.size()); end
    else foreach (exp[i]) begin
      n_vec++; if (wlog[i] !== exp[i]) begin n_err++; $display("FAIL gap_write%0d: got %h expected %h", i, wlog[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp[$];
    wlog.delete();
    req_data[31:24] = 8'h61; req_valid = 4'b1000;
    cyc();
    cyc(); req_data[31:24] = 8'h62;
    cyc(); req_data[31:24] = 8'h63; rst = 1'b1; #1;
    n_vec++; if (w_inc_en !== 1'b0) begin n_err++; $display("FAIL rstmid_wen: got %b expected 0", w_inc_en); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rstmid_ready: got %b expected 0000", req_ready); end
    cyc(); rst = 1'b0; req_data[15:8] = 8'h71; req_last = 4'b0010; req_valid = 4'b1010; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL rstmid_grant: got %b expected 0000", grant); end
    n_vec++; if (w_inc_en !== 1'b0) begin n_err++; $display("FAIL rstmid_wen2: got %b expected 0", w_inc_en); end
    n_vec++; if (w_data !== 8'h00) begin n_err++; $display("FAIL rstmid_wdata: got %h expected 00", w_data); end
    n_vec++; if (dut.rr_ptr !== 2'd0) begin n_err++; $display("FAIL rstmid_rrptr: got %0d expected 0", dut.rr_ptr); end
    n_vec++; if (dut.beat_cnt !== 3'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d expected 0", dut.beat_cnt); end
    cyc(); #1;
    n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL rstmid_regrant: got %b expected 0010", grant); end
    n_vec++; if (w_data !== 8'h71) begin n_err++; $display("FAIL rstmid_data: got %h expected 71", w_data); end
    cyc(); req_valid = 4'b0000; req_last = 4'b0000; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b expected 0", busy); end
    exp = '{12'h861, 12'h862, 12'h271};
    n_vec++; if (wlog.size() != exp.size()) begin n_err++; $display("FAIL rstmid_nwrites: got %0d expected %0d", wlog.size(), exp.size()); end
    else foreach (exp[i]) begin
      n_vec++; if (wlog[i] !== exp[i]) begin n_err++; $display("FAIL rstmid_write%0d: got %h expected %h", i, wlog[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_burst_cap();
    test_valid_gap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
